// File: rtl/eep_ctrl.sv
// eep_ctrl: sequencer for the 4-word x 14-bit EEPROM in cbc_dig.
//
// After reset it boot-loads xset/P/I/D (EEPROM words 0..3) into the PID
// coefficient registers. It then serves single read/write commands from the
// config command decoder. A write selects the EEPROM for one cycle and then
// holds the charge pump on for PMP_CYCLES cycles. Every write is also copied
// to the coefficient registers so the datapath tracks the EEPROM contents.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_req/wr/addr/wdata command from decoder (level req, held until ack)
//   cmd_ack, cmd_rdata    completion pulse, read data
//   busy, init_done       status
//   coef_ld/addr/data     coefficient load strobe (0=xset 1=P 2=I 3=D)
//   eep_addr/wdata/cs_n/r_w_n, chrg_pmp_en   EEPROM macro control
//   eep_rd_data           EEPROM read data, valid the cycle after a read select
module eep_ctrl #(
    parameter int unsigned PMP_CYCLES = 3000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_req,
    input  logic        cmd_wr,
    input  logic [1:0]  cmd_addr,
    input  logic [13:0] cmd_wdata,
    output logic        cmd_ack,
    output logic [13:0] cmd_rdata,
    output logic        busy,
    output logic        init_done,
    output logic        coef_ld,
    output logic [1:0]  coef_addr,
    output logic [13:0] coef_data,
    output logic [1:0]  eep_addr,
    output logic [13:0] eep_wdata,
    output logic        eep_cs_n,
    output logic        eep_r_w_n,
    output logic        chrg_pmp_en,
    input  logic [13:0] eep_rd_data
);

    localparam logic [2:0] S_BOOT_RD  = 3'd0;
    localparam logic [2:0] S_BOOT_CAP = 3'd1;
    localparam logic [2:0] S_IDLE     = 3'd2;
    localparam logic [2:0] S_RD       = 3'd3;
    localparam logic [2:0] S_RD_CAP   = 3'd4;
    localparam logic [2:0] S_WR       = 3'd5;
    localparam logic [2:0] S_PUMP     = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    localparam logic [23:0] PMP_LD = 24'(PMP_CYCLES - 1);

    logic [2:0]  state, ns;
    logic [1:0]  boot_addr, ba_nxt;
    logic        boot_go;      // first BOOT_RD cycle after reset has not driven the EEPROM yet
    logic [1:0]  lat_addr;
    logic [13:0] lat_wdata;
    logic [23:0] pmp_cnt;
    logic        boot_last;
    logic        init_nxt;

    assign boot_last = (state == S_BOOT_CAP) && (boot_addr == 2'd3);
    assign init_nxt  = init_done | boot_last;

    always_comb begin
        ns     = state;
        ba_nxt = boot_addr;
        case (state)
            S_BOOT_RD:  if (boot_go) ns = S_BOOT_CAP;
            S_BOOT_CAP: begin
                if (boot_addr == 2'd3) begin
                    ns = S_IDLE;
                end else begin
                    ns     = S_BOOT_RD;
                    ba_nxt = boot_addr + 2'd1;
                end
            end
            S_IDLE:     if (cmd_req) ns = cmd_wr ? S_WR : S_RD;
            S_RD:       ns = S_RD_CAP;
            S_RD_CAP:   ns = S_DONE;
            S_WR:       ns = S_PUMP;
            S_PUMP:     if (pmp_cnt == 24'd0) ns = S_DONE;
            S_DONE:     ns = S_IDLE;
            default:    ns = S_BOOT_RD;
        endcase
    end

    // Outputs are registered from the next state, so each output is valid in
    // the same cycle the FSM occupies the corresponding state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_BOOT_RD;
            boot_addr   <= 2'd0;
            boot_go     <= 1'b0;
            lat_addr    <= 2'd0;
            lat_wdata   <= 14'd0;
            pmp_cnt     <= 24'd0;
            cmd_ack     <= 1'b0;
            cmd_rdata   <= 14'd0;
            busy        <= 1'b1;
            init_done   <= 1'b0;
            coef_ld     <= 1'b0;
            coef_addr   <= 2'd0;
            coef_data   <= 14'd0;
            eep_addr    <= 2'd0;
            eep_wdata   <= 14'd0;
            eep_cs_n    <= 1'b1;
            eep_r_w_n   <= 1'b1;
            chrg_pmp_en <= 1'b0;
        end else begin
            state       <= ns;
            boot_addr   <= ba_nxt;
            if (state == S_BOOT_RD) boot_go <= 1'b1;

            eep_cs_n    <= ~((ns == S_BOOT_RD) || (ns == S_RD) || (ns == S_WR));
            eep_r_w_n   <= (ns != S_WR);
            chrg_pmp_en <= (ns == S_PUMP);
            cmd_ack     <= (ns == S_DONE);
            busy        <= ~init_nxt | (ns != S_IDLE);
            init_done   <= init_nxt;

            if (ns == S_BOOT_RD) eep_addr <= ba_nxt;

            // Command fields are latched once; later input changes are ignored.
            if (state == S_IDLE && cmd_req) begin
                lat_addr  <= cmd_addr;
                lat_wdata <= cmd_wdata;
                eep_addr  <= cmd_addr;
                if (cmd_wr) eep_wdata <= cmd_wdata;
            end

            if (state == S_WR)
                pmp_cnt <= PMP_LD;
            else if (state == S_PUMP && pmp_cnt != 24'd0)
                pmp_cnt <= pmp_cnt - 24'd1;

            // EEPROM data is valid during the capture state; sample at its end.
            if (state == S_RD_CAP) cmd_rdata <= eep_rd_data;

            coef_ld <= 1'b0;
            if (state == S_BOOT_CAP) begin
                coef_ld   <= 1'b1;
                coef_addr <= boot_addr;
                coef_data <= eep_rd_data;
            end else if (state == S_PUMP && pmp_cnt == 24'd0) begin
                coef_ld   <= 1'b1;
                coef_addr <= lat_addr;
                coef_data <= lat_wdata;
            end
        end
    end

endmodule

// File: tb/tb_eep_ctrl.sv
// tb_eep_ctrl: directed bench for eep_ctrl with a behavioural EEPROM model.
module tb_eep_ctrl;
    localparam int PMP = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_req, cmd_wr;
    logic [1:0]  cmd_addr;
    logic [13:0] cmd_wdata;
    logic        cmd_ack, busy, init_done, coef_ld;
    logic [13:0] cmd_rdata, coef_data, eep_wdata, eep_rd_data;
    logic [1:0]  coef_addr, eep_addr;
    logic        eep_cs_n, eep_r_w_n, chrg_pmp_en;

    always #5 clk = ~clk;

    eep_ctrl #(.PMP_CYCLES(PMP)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_req(cmd_req), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_ack(cmd_ack), .cmd_rdata(cmd_rdata), .busy(busy), .init_done(init_done),
        .coef_ld(coef_ld), .coef_addr(coef_addr), .coef_data(coef_data),
        .eep_addr(eep_addr), .eep_wdata(eep_wdata), .eep_cs_n(eep_cs_n),
        .eep_r_w_n(eep_r_w_n), .chrg_pmp_en(chrg_pmp_en), .eep_rd_data(eep_rd_data)
    );

    // EEPROM model: read data one cycle after select; a write commits only
    // after the pump has been on for exactly PMP cycles.
    logic [13:0] mem [4];
    logic        mem_init = 1'b1;
    logic        pend;
    logic [1:0]  pa;
    logic [13:0] pd;
    int          pc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 1'b0;
            pc   <= 0;
            eep_rd_data <= 14'd0;
            if (mem_init) begin
                mem[0] <= 14'h0100; mem[1] <= 14'h0800;
                mem[2] <= 14'h0020; mem[3] <= 14'h1FFF;
            end
        end else begin
            if (!eep_cs_n && eep_r_w_n) eep_rd_data <= mem[eep_addr];
            if (!eep_cs_n && !eep_r_w_n) begin
                pend <= 1'b1; pa <= eep_addr; pd <= eep_wdata; pc <= 0;
            end else if (pend && chrg_pmp_en) begin
                pc <= pc + 1;
            end else if (pend) begin
                if (pc == PMP) mem[pa] <= pd;
                pend <= 1'b0;
            end
        end
    end

    int viol = 0;
    always @(negedge clk) if (rst_n && !eep_cs_n && chrg_pmp_en) viol++;

    int errors = 0, checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Boot load: selects in cycles 1/3/5/7, loads in 3/5/7/9 with words 0..3.
    task automatic boot_chk(input logic [3:0][13:0] ev, input bit with_req);
        int cs_m = 0, ld_m = 0, idx;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (with_req && c == 1) begin
                cmd_req = 1'b1; cmd_wr = 1'b0; cmd_addr = 2'd2; cmd_wdata = 14'h3FFF;
            end
            if (!eep_cs_n) begin
                cs_m |= (1 << c);
                chk("boot_sel_addr", 32'(eep_addr), (c - 1) / 2);
                chk("boot_sel_rwn", 32'(eep_r_w_n), 1);
            end
            if (coef_ld) begin
                ld_m |= (1 << c);
                idx = (c >= 3) ? (c - 3) / 2 : 0;
                chk("boot_coef_addr", 32'(coef_addr), idx);
                chk("boot_coef_data", 32'(coef_data), 32'(ev[idx]));
            end
            if (c == 8) chk("init_before", 32'(init_done), 0);
            if (c == 9) begin
                chk("init_after", 32'(init_done), 1);
                chk("busy_after", 32'(busy), 0);
            end
        end
        chk("boot_sel_cycles", cs_m, 32'h0AA);
        chk("boot_ld_cycles", ld_m, 32'h2A8);
    endtask

    int          w_sel, w_wsel, w_pump, w_ack, w_ld;
    logic [1:0]  w_sel_addr, w_ld_addr;
    logic [13:0] w_wdata, w_ld_data, w_rdata;

    task automatic issue(input logic wr, input logic [1:0] a, input logic [13:0] d);
        @(negedge clk);
        cmd_req = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_wdata = d;
    endtask

    // Observe one transaction until cmd_ack (bounded); drop req on ack.
    task automatic watch(input int maxc);
        w_sel = 0; w_wsel = 0; w_pump = 0; w_ack = -1; w_ld = 0;
        for (int i = 1; i <= maxc; i++) begin
            @(negedge clk);
            if (!eep_cs_n) begin
                w_sel++;
                if (!eep_r_w_n) w_wsel++;
                w_sel_addr = eep_addr; w_wdata = eep_wdata;
            end
            if (chrg_pmp_en) w_pump++;
            if (coef_ld) begin w_ld++; w_ld_addr = coef_addr; w_ld_data = coef_data; end
            if (cmd_ack) begin
                w_ack = i; w_rdata = cmd_rdata; cmd_req = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a1, a2, s2, nack, np;
        logic [13:0] r1;
        logic b2_rwn, b2_ack_gap, ack_seen;
        cmd_req = 1'b0; cmd_wr = 1'b0; cmd_addr = 2'd0; cmd_wdata = 14'd0;
        repeat (3) @(negedge clk);

        chk("rst_cs_n", 32'(eep_cs_n), 1);
        chk("rst_r_w_n", 32'(eep_r_w_n), 1);
        chk("rst_pump", 32'(chrg_pmp_en), 0);
        chk("rst_ack", 32'(cmd_ack), 0);
        chk("rst_coef_ld", 32'(coef_ld), 0);
        chk("rst_init", 32'(init_done), 0);
        chk("rst_busy", 32'(busy), 1);
        chk("rst_addr", 32'(eep_addr), 0);
        chk("rst_wdata", 32'(eep_wdata), 0);
        chk("rst_rdata", 32'(cmd_rdata), 0);
        chk("rst_coef", 32'({coef_addr, coef_data}), 0);

        // Boot with a read request (addr 2) pending from cycle 1.
        rst_n = 1'b1; mem_init = 1'b0;
        boot_chk({14'h1FFF, 14'h0020, 14'h0800, 14'h0100}, 1'b1);
        watch(20);
        chk("rd_lat", w_ack, 3);
        chk("rd_sel", w_sel, 1);
        chk("rd_wsel", w_wsel, 0);
        chk("rd_sel_addr", 32'(w_sel_addr), 2);
        chk("rd_data", 32'(w_rdata), 32'h0020);
        chk("rd_no_ld", w_ld, 0);

        // Write addr 1 with write-through.
        issue(1'b1, 2'd1, 14'h0A5A);
        watch(40);
        chk("wr_sel", w_sel, 1);
        chk("wr_wsel", w_wsel, 1);
        chk("wr_sel_addr", 32'(w_sel_addr), 1);
        chk("wr_wdata", 32'(w_wdata), 32'h0A5A);
        chk("wr_pump", w_pump, PMP);
        chk("wr_lat", w_ack, PMP + 2);
        chk("wr_ld", w_ld, 1);
        chk("wr_ld_addr", 32'(w_ld_addr), 1);
        chk("wr_ld_data", 32'(w_ld_data), 32'h0A5A);

        issue(1'b0, 2'd1, 14'd0);
        watch(20);
        chk("rdback_lat", w_ack, 3);
        chk("rdback_data", 32'(w_rdata), 32'h0A5A);

        // Back-to-back: read addr 3, then (req held) write addr 2.
        issue(1'b0, 2'd3, 14'd0);
        a1 = -1; a2 = -1; s2 = -1; nack = 0; b2_rwn = 1'b1; b2_ack_gap = 1'b1; r1 = 14'd0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (cmd_ack) nack++;
            if (a1 > 0 && i == a1 + 1) b2_ack_gap = cmd_ack;
            if (a1 > 0 && s2 < 0 && !eep_cs_n) begin s2 = i; b2_rwn = eep_r_w_n; end
            if (cmd_ack) begin
                if (a1 < 0) begin
                    a1 = i; r1 = cmd_rdata;
                    cmd_wr = 1'b1; cmd_addr = 2'd2; cmd_wdata = 14'h1234;
                end else begin
                    a2 = i; cmd_req = 1'b0;
                    break;
                end
            end
        end
        chk("b2b_ack1", a1, 3);
        chk("b2b_rdata", 32'(r1), 32'h1FFF);
        chk("b2b_ack_width", 32'(b2_ack_gap), 0);
        chk("b2b_sel2", s2, 5);
        chk("b2b_sel2_rwn", 32'(b2_rwn), 0);
        chk("b2b_ack2", a2, 5 + PMP + 1);
        chk("b2b_nack", nack, 2);

        // Reset during the 8th pump cycle of a write to addr 3.
        issue(1'b1, 2'd3, 14'h0555);
        np = 0; ack_seen = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (cmd_ack) ack_seen = 1'b1;
            if (chrg_pmp_en) np++;
            if (np == 8) break;
        end
        chk("mid_pump_cnt", np, 8);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pump", 32'(chrg_pmp_en), 0);
        chk("arst_cs_n", 32'(eep_cs_n), 1);
        chk("arst_busy", 32'(busy), 1);
        chk("arst_init", 32'(init_done), 0);
        cmd_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            ack_seen |= cmd_ack;
        end
        chk("arst_no_ack", 32'(ack_seen), 0);
        rst_n = 1'b1;
        boot_chk({14'h1FFF, 14'h1234, 14'h0A5A, 14'h0100}, 1'b0);
        chk("reboot_rdata", 32'(cmd_rdata), 0);
        chk("pump_vs_cs", viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
